// File: rtl/staircase_if.sv
// Control and waveform bundle between the staircase generator and its consumers.
// The master side drives enable/steps; the slave (generator) drives the waveform outputs.
interface staircase_if #(
  parameter int CODE_W = 8
);
  logic              enable;
  logic [3:0]        steps;
  logic [3:0]        level;
  logic [CODE_W-1:0] dac_code;
  logic              step_strobe;
  logic              wrap;

  modport master (
    output enable, steps,
    input  level, dac_code, step_strobe, wrap
  );

  modport slave (
    input  enable, steps,
    output level, dac_code, step_strobe, wrap
  );
endinterface

// File: rtl/staircase_generator.sv
// Periodic staircase: n equal rises from 0 to full scale, each plateau held DWELL_CYCLES,
// then wrap to 0. The step count is only re-sampled at start-up and at wrap.
module staircase_generator #(
  parameter int DWELL_CYCLES = 100_000,
  parameter int CODE_W       = 8
) (
  input  logic         clk,
  input  logic         reset,
  staircase_if.slave   bus
);

  localparam int CNT_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [3:0]        n_q, n_d;
  logic [3:0]        level_q, level_d;
  logic [CNT_W-1:0]  dwell_cnt_q, dwell_cnt_d;
  logic [CODE_W-1:0] dac_code_q, dac_code_d;
  logic              step_strobe_q, step_strobe_d;
  logic              wrap_q, wrap_d;
  logic [3:0]        steps_clamped;

  function automatic logic [3:0] clamp_steps(input logic [3:0] s);
    clamp_steps = (s > 4'd10) ? 4'd10 : s;
  endfunction

  // floor(255/n); n=0 yields 0 so an idle block never produces a code
  function automatic logic [CODE_W-1:0] height_lut(input logic [3:0] n);
    case (n)
      4'd1:    height_lut = CODE_W'(255);
      4'd2:    height_lut = CODE_W'(127);
      4'd3:    height_lut = CODE_W'(85);
      4'd4:    height_lut = CODE_W'(63);
      4'd5:    height_lut = CODE_W'(51);
      4'd6:    height_lut = CODE_W'(42);
      4'd7:    height_lut = CODE_W'(36);
      4'd8:    height_lut = CODE_W'(31);
      4'd9:    height_lut = CODE_W'(28);
      4'd10:   height_lut = CODE_W'(25);
      default: height_lut = '0;
    endcase
  endfunction

  assign steps_clamped = clamp_steps(bus.steps);

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    level_d       = level_q;
    dwell_cnt_d   = dwell_cnt_q;
    step_strobe_d = 1'b0;
    wrap_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        level_d     = 4'd0;
        dwell_cnt_d = '0;
        if (bus.enable && (steps_clamped != 4'd0)) begin
          n_d     = steps_clamped;
          state_d = S_RUN;
        end
      end
      default: begin
        // Dropping enable beats a coincident terminal count: no strobe.
        if (!bus.enable) begin
          state_d     = S_IDLE;
          level_d     = 4'd0;
          dwell_cnt_d = '0;
        end else if (dwell_cnt_q == CNT_LAST) begin
          dwell_cnt_d   = '0;
          step_strobe_d = 1'b1;
          if (level_q < n_q) begin
            level_d = level_q + 4'd1;
          end else begin
            level_d = 4'd0;
            wrap_d  = 1'b1;
            n_d     = steps_clamped;
            if (steps_clamped == 4'd0) begin
              state_d = S_IDLE;
            end
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q + CNT_W'(1);
        end
      end
    endcase

    // Product never exceeds 255, so the CODE_W-wide result cannot overflow.
    dac_code_d = CODE_W'(level_d) * height_lut(n_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      n_q           <= 4'd0;
      level_q       <= 4'd0;
      dwell_cnt_q   <= '0;
      dac_code_q    <= '0;
      step_strobe_q <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      level_q       <= level_d;
      dwell_cnt_q   <= dwell_cnt_d;
      dac_code_q    <= dac_code_d;
      step_strobe_q <= step_strobe_d;
      wrap_q        <= wrap_d;
    end
  end

  assign bus.level       = level_q;
  assign bus.dac_code    = dac_code_q;
  assign bus.step_strobe = step_strobe_q;
  assign bus.wrap        = wrap_q;

endmodule

// File: tb/tb_staircase_generator.sv
// Scoreboard bench for staircase_generator: a time-based waveform model predicts each
// cycle's outputs into a queue, and a monitor compares them one cycle at a time.
module tb_staircase_generator;

  localparam int DW = 4;

  typedef struct {
    logic [3:0] level;
    logic [7:0] dac;
    logic       ss;
    logic       wr;
  } exp_t;

  logic clk;
  logic reset;
  exp_t exp_q[$];
  int   checks;
  int   errors;

  // Reference model state: whether a staircase is running, its step count,
  // and the edge index at which its current period's level 0 first appeared.
  bit   m_running;
  int   m_n;
  int   m_t0;
  int   edge_no;

  staircase_if #(.CODE_W(8)) sif ();

  staircase_generator #(.DWELL_CYCLES(DW), .CODE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clamp10(input int s);
    return (s > 10) ? 10 : s;
  endfunction

  // Predict the outputs after the edge that samples (r, en, st).
  function automatic exp_t model_edge(input bit r, input bit en, input int st);
    exp_t e;
    int   elapsed;
    int   plateau;
    int   lvl;
    e.level = '0; e.dac = '0; e.ss = 1'b0; e.wr = 1'b0;
    lvl = 0;
    if (r) begin
      m_running = 1'b0;
      m_n       = 0;
    end else if (!m_running) begin
      if (en && clamp10(st) != 0) begin
        m_running = 1'b1;
        m_n       = clamp10(st);
        m_t0      = edge_no;
      end
    end else if (!en) begin
      m_running = 1'b0;
    end else begin
      elapsed = edge_no - m_t0;
      plateau = elapsed / DW;
      if (elapsed % DW == 0) e.ss = 1'b1;
      if (plateau == m_n + 1) begin
        e.wr = 1'b1;
        m_t0 = edge_no;
        if (clamp10(st) == 0) m_running = 1'b0;
        else m_n = clamp10(st);
      end else begin
        lvl = plateau;
      end
    end
    if (m_running) begin
      e.level = 4'(lvl);
      e.dac   = 8'(lvl * (255 / m_n));
    end
    return e;
  endfunction

  task automatic drive(input bit r, input bit en, input int st, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      reset      = r;
      sif.enable = en;
      sif.steps  = 4'(st);
      edge_no++;
      exp_q.push_back(model_edge(r, en, st));
    end
  endtask

  // Monitor: the DUT presents a result every cycle; compare it after the edge settles.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (sif.level !== e.level || sif.dac_code !== e.dac ||
            sif.step_strobe !== e.ss || sif.wrap !== e.wr) begin
          errors++;
          $display("FAIL cycle%0d: got level=%0d dac=%0d strobe=%0b wrap=%0b, expected level=%0d dac=%0d strobe=%0b wrap=%0b",
                   edge_no, sif.level, sif.dac_code, sif.step_strobe, sif.wrap,
                   e.level, e.dac, e.ss, e.wr);
        end
      end
    end
  end

  initial begin
    int st;
    bit en;
    bit r;
    checks    = 0;
    errors    = 0;
    m_running = 1'b0;
    m_n       = 0;
    m_t0      = 0;
    edge_no   = 0;
    reset      = 1'b1;
    sif.enable = 1'b0;
    sif.steps  = 4'd0;

    // Power-up reset, then a 3-step staircase
    drive(1, 0, 0, 2);
    drive(0, 1, 3, 40);
    // Fresh start, change to 10 steps while on level 1
    drive(1, 1, 3, 2);
    drive(0, 1, 3, 6);
    drive(0, 1, 10, 100);
    // Square wave
    drive(0, 1, 1, 28);
    // Clamp 15 -> 10
    drive(0, 1, 15, 60);
    // Zero before wrap drops to idle; zero at start stays idle
    drive(0, 1, 0, 60);
    // Enable dropped mid-plateau, then resumed
    drive(0, 1, 5, 10);
    drive(0, 0, 5, 3);
    drive(0, 1, 5, 30);
    // Reset in the middle of a run with enable held, then restart
    drive(1, 1, 5, 2);
    drive(0, 1, 5, 30);

    // Randomized phase: occasional resets, enable drops and step changes
    st = 4;
    for (int i = 0; i < 900; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 24) == 0) st = $urandom_range(0, 15);
      drive(r, en, st, 1);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
